seq_nbit_multiplier: RTL and testbench
======================================

SEQ_NBIT_MULTIPLIER -- requirements
Module: seq_nbit_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width (legal range N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair and signed_mode are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port multiplicand, input, N bits: operand A.
REQ-007 The block SHALL have port multiplier, input, N bits: operand B.
REQ-008 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-009 The block SHALL have port out_valid, output, 1 bit: product is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-011 The block SHALL have port product, output, 2N bits: A*B, full width, no truncation.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-014 in_ready SHALL equal (state==IDLE) AND NOT rst; out_valid SHALL equal (state==DONE).
REQ-015 An accept SHALL occur on any rising edge where in_valid and in_ready are both 1.
- Captured: A, B, signed_mode.
- If signed_mode=1: store |A|, |B| as N-bit unsigned values (magnitude of -2^(N-1) = 2^(N-1) fits); store sign = A[N-1] XOR B[N-1].
- If signed_mode=0: store sign = 0.
- Clear the 2N-bit accumulator and step counter; state goes to CALC.
REQ-016 Operand inputs SHALL be sampled only at the accept edge; later changes have no effect on the operation in flight.
REQ-017 In CALC, each edge SHALL perform one shift-add step: if the current multiplier bit is 1, add the multiplicand shifted by the step index to the accumulator; then increment the counter.
REQ-018 The Nth CALC edge SHALL:
- register product = sign ? two's-complement negation of the final accumulator : final accumulator (2N-bit wrap);
- enter DONE.
REQ-019 out_valid SHALL rise exactly N edges after the accept edge, independent of operand values (zero operands give no early exit).
REQ-020 In DONE, product SHALL be held stable until an edge where out_ready=1; that edge returns the state to IDLE.
REQ-021 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE, with no capture and no error.
REQ-022 Minimum issue interval SHALL be N+2 cycles: accept, N-1 further CALC cycles, DONE, IDLE.
REQ-023 product SHALL retain its last value after the DONE handshake until the next Nth CALC edge overwrites it.

Reset
REQ-024 While rst=1, the block SHALL force state=IDLE, product=0, out_valid=0, busy=0, in_ready=0, and clear the accumulator, counter and sign, all asynchronously.
REQ-025 Reset asserted mid-CALC or in DONE SHALL abort the operation with no output; the first accept after rst deasserts SHALL proceed normally.

Verification (N=8)
REQ-026 Unsigned 13*11, out_ready=1 -> product=0x008F; out_valid high 8 edges after accept for exactly 1 cycle.
REQ-027 Unsigned 255*255 -> 0xFE01; signed 0x80*0x80 (-128*-128) -> 0x4000; signed 0xFD*0x05 (-3*5) -> 0xFFF1.
REQ-028 Unsigned 0*0xA5 -> product=0x0000 with full 8-cycle latency; busy high throughout.
REQ-029 out_ready held 0 for 5 cycles in DONE, with in_valid=1 and new operands -> product and out_valid stable, in_ready=0, no capture; out_ready=1 -> IDLE, then the next accept proceeds.
REQ-030 rst pulsed after the 4th CALC edge -> out_valid=0, product=0, busy=0 immediately; then unsigned 7*6 -> 0x002A with normal latency.
REQ-031 Back-to-back accepts with in_valid and out_ready held at 1 -> accepts spaced exactly 10 cycles apart, every product correct.

Source files
------------

// File: rtl/seq_nbit_multiplier_if.sv
// Operand/product handshake bundle for the sequential multiplier.
// The master drives operands and out_ready; the slave (the multiplier) answers.
interface seq_nbit_multiplier_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;
    logic             busy;

    modport master (
        output in_valid, multiplicand, multiplier, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_nbit_multiplier.sv
// Sequential shift-add multiplier: one partial product per cycle, fixed N-cycle latency.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
module seq_nbit_multiplier #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_nbit_multiplier_if.slave bus_io
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             sign_q, sign_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N-1:0]     a_abs;
    logic [N-1:0]     b_abs;
    logic [2*N-1:0]   addend;
    logic [2*N-1:0]   acc_sum;

    // Magnitude of -2^(N-1) wraps to 2^(N-1), which is exactly right as unsigned.
    assign a_abs = (bus_io.signed_mode && bus_io.multiplicand[N-1]) ? -bus_io.multiplicand
                                                                    : bus_io.multiplicand;
    assign b_abs = (bus_io.signed_mode && bus_io.multiplier[N-1]) ? -bus_io.multiplier
                                                                  : bus_io.multiplier;

    assign addend  = b_q[cnt_q] ? ({{N{1'b0}}, a_q} << cnt_q) : '0;
    assign acc_sum = acc_q + addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus_io.in_valid) begin
                    a_d     = a_abs;
                    b_d     = b_abs;
                    sign_d  = bus_io.signed_mode &
                              (bus_io.multiplicand[N-1] ^ bus_io.multiplier[N-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    product_d = sign_q ? -acc_sum : acc_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus_io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_io.in_ready  = (state_q == IDLE) && !rst;
    assign bus_io.out_valid = (state_q == DONE);
    assign bus_io.busy      = (state_q != IDLE);
    assign bus_io.product   = product_q;
endmodule

// File: tb/tb_seq_nbit_multiplier.sv
// Randomised and directed checks of seq_nbit_multiplier against a plain-arithmetic model.
module tb_seq_nbit_multiplier;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   accept_cyc[$];

    seq_nbit_multiplier_if #(.N(N)) bus ();

    seq_nbit_multiplier #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change just after a rising edge, so the falling edge sees what the next edge will.
    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) accept_cyc.push_back(cyc);
        cyc++;
    end

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic s);
        longint x;
        longint y;
        logic [63:0] p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[2*N-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: wait for in_ready, accept, measure latency, then hold DONE for 'stall' cycles.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input int stall, input string name);
        logic [2*N-1:0] exp_p;
        int t;
        int lat;
        exp_p = ref_mul(a, b, s);
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL %s ready_wait: in_ready=%0b required 1", name, bus.in_ready);
        end
        bus.in_valid     = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.signed_mode  = s;
        bus.out_ready    = (stall == 0);
        tick();
        bus.in_valid     = 1'b0;
        bus.multiplicand = N'($urandom);
        bus.multiplier   = N'($urandom);
        bus.signed_mode  = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < N + 5) begin
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy: busy=%0b required 1 at step %0d", name, bus.busy, lat);
            end
            tick();
            lat++;
        end
        checks++;
        if (lat !== N) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required %0d", name, lat, N);
        end
        checks++;
        if (bus.product !== exp_p) begin
            errors++;
            $display("FAIL %s product: %h*%h s=%0b got %h required %h", name, a, b, s,
                     bus.product, exp_p);
        end
        if (stall > 0) begin
            bus.in_valid     = 1'b1;
            bus.multiplicand = N'($urandom);
            bus.multiplier   = N'($urandom);
            for (int i = 0; i < stall; i++) begin
                tick();
                checks++;
                if (bus.out_valid !== 1'b1 || bus.product !== exp_p || bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stall: out_valid=%0b product=%h in_ready=%0b required 1/%h/0",
                             name, bus.out_valid, bus.product, bus.in_ready, exp_p);
                end
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: out_valid=%0b busy=%0b in_ready=%0b required 0/0/1",
                     name, bus.out_valid, bus.busy, bus.in_ready);
        end
        checks++;
        if (bus.product !== exp_p) begin
            errors++;
            $display("FAIL %s hold: product=%h required %h", name, bus.product, exp_p);
        end
        $display("op %s: %h*%h signed=%0b product=%h expected=%h latency=%0d",
                 name, a, b, s, bus.product, exp_p, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.multiplicand = 8'h12;
        bus.multiplier = 8'h34;
        bus.signed_mode = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.product !== '0) begin
            errors++;
            $display("FAIL reset: in_ready=%0b out_valid=%0b busy=%0b product=%h required 0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.product);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b busy=%0b required 1/0", bus.in_ready, bus.busy);
        end
        $display("reset: in_ready=%0b busy=%0b product=%h", bus.in_ready, bus.busy, bus.product);
    endtask

    task automatic test_directed();
        run_op(8'd13, 8'd11, 1'b0, 0, "u13x11");
        run_op(8'hFF, 8'hFF, 1'b0, 0, "u255x255");
        run_op(8'h80, 8'h80, 1'b1, 0, "s-128x-128");
        run_op(8'hFD, 8'h05, 1'b1, 0, "s-3x5");
        run_op(8'h00, 8'hA5, 1'b0, 0, "u0xA5");
        run_op(8'h7F, 8'h80, 1'b1, 0, "s127x-128");
    endtask

    task automatic test_backpressure();
        run_op(8'h9C, 8'h3B, 1'b1, 5, "stall");
        run_op(8'h21, 8'h42, 1'b0, 0, "after_stall");
    endtask

    task automatic test_reset_abort();
        int t;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        bus.in_valid = 1'b1;
        bus.multiplicand = 8'hEE;
        bus.multiplier = 8'hDD;
        bus.signed_mode = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.product !== '0 || bus.busy !== 1'b0 ||
            bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort: out_valid=%0b product=%h busy=%0b in_ready=%0b required 0/0/0/0",
                     bus.out_valid, bus.product, bus.busy, bus.in_ready);
        end
        $display("abort: out_valid=%0b product=%h busy=%0b", bus.out_valid, bus.product, bus.busy);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_op(8'd7, 8'd6, 1'b0, 0, "u7x6_after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), 0, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic s;
        logic [2*N-1:0] exp_p;
        int lat;
        accept_cyc.delete();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            s = 1'($urandom);
            exp_p = ref_mul(a, b, s);
            bus.multiplicand = a;
            bus.multiplier   = b;
            bus.signed_mode  = s;
            tick();
            lat = 0;
            while (!bus.out_valid && lat < N + 5) begin
                tick();
                lat++;
            end
            checks++;
            if (bus.product !== exp_p || lat !== N) begin
                errors++;
                $display("FAIL b2b%0d: product=%h latency=%0d required %h/%0d",
                         i, bus.product, lat, exp_p, N);
            end
            $display("b2b%0d: %h*%h signed=%0b product=%h expected=%h", i, a, b, s, bus.product, exp_p);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        checks++;
        if (accept_cyc.size() !== 5) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d required 5", accept_cyc.size());
        end
        for (int i = 1; i < accept_cyc.size(); i++) begin
            checks++;
            if (accept_cyc[i] - accept_cyc[i-1] !== N + 2) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d cycles required %0d",
                         i, accept_cyc[i] - accept_cyc[i-1], N + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
